// File: rtl/bist_pkg.sv
// Shared types and default polynomials for the netlist BIST controller.
package bist_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [13:0] DEF_LFSR_TAPS = 14'h3802;
    localparam logic [13:0] DEF_LFSR_SEED = 14'h0001;
    localparam logic [7:0]  DEF_MISR_TAPS = 8'hB8;
    localparam logic [7:0]  DEF_MISR_SEED = 8'h00;
endpackage

// File: rtl/netlist_bist_ctrl_if.sv
// Pin bundle between the BIST controller, its host and the netlist under test.
interface netlist_bist_ctrl_if #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [OUT_W-1:0] golden;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;

    // master is the host together with the netlist; slave is the controller
    modport master (output start, num_patterns, golden, dut_out,
                    input  dut_in, busy, done, pass, signature);
    modport slave  (input  start, num_patterns, golden, dut_out,
                    output dut_in, busy, done, pass, signature);
endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci shift step: shift left, feed back the parity of the tapped bits.
module lfsr_step #(
    parameter int           W    = 8,
    parameter logic [W-1:0] TAPS = '0
) (
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);
    assign nxt = {cur[W-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/netlist_bist_ctrl.sv
// LFSR-driven self test of a combinational netlist with MISR signature compaction.
module netlist_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               IN_W      = 14,
    parameter int               OUT_W     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [IN_W-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [IN_W-1:0]  LFSR_SEED = DEF_LFSR_SEED,
    parameter logic [OUT_W-1:0] MISR_TAPS = DEF_MISR_TAPS,
    parameter logic [OUT_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
    input logic               clk,
    input logic               rst,
    netlist_bist_ctrl_if.slave bus
);
    state_t           state;
    logic [IN_W-1:0]  lfsr, lfsr_nxt, dut_in_q;
    logic [OUT_W-1:0] misr, misr_shift, misr_nxt;
    logic [OUT_W-1:0] out_q, golden_q, sig_q;
    logic [CNT_W-1:0] cnt, n_q;
    logic             out_vld, busy_q, done_q, pass_q;

    lfsr_step #(.W(IN_W),  .TAPS(LFSR_TAPS)) u_lfsr (.cur(lfsr), .nxt(lfsr_nxt));
    lfsr_step #(.W(OUT_W), .TAPS(MISR_TAPS)) u_misr (.cur(misr), .nxt(misr_shift));

    assign misr_nxt = misr_shift ^ out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lfsr     <= '0;
            misr     <= '0;
            cnt      <= '0;
            n_q      <= '0;
            out_q    <= '0;
            out_vld  <= 1'b0;
            golden_q <= '0;
            dut_in_q <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            out_vld <= 1'b0;
            // out_q lags the vector by one edge, so compaction trails capture by one
            if (out_vld) misr <= misr_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        golden_q <= bus.golden;
                        n_q      <= bus.num_patterns;
                        misr     <= MISR_SEED;
                        pass_q   <= 1'b0;
                        if (bus.num_patterns == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            sig_q  <= MISR_SEED;
                            pass_q <= (MISR_SEED == bus.golden);
                        end else begin
                            state    <= ST_RUN;
                            lfsr     <= LFSR_SEED;
                            dut_in_q <= LFSR_SEED;
                            cnt      <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    out_q   <= bus.dut_out;
                    out_vld <= 1'b1;
                    lfsr    <= lfsr_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == n_q - CNT_W'(1)) begin
                        state    <= ST_DRAIN;
                        dut_in_q <= '0;
                    end else begin
                        dut_in_q <= lfsr_nxt;
                    end
                end
                ST_DRAIN: begin
                    // result registered on entry so it is already valid while done is high
                    state  <= ST_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    sig_q  <= misr_nxt;
                    pass_q <= (misr_nxt == golden_q);
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Randomized bench for netlist_bist_ctrl against a sequence-level signature model.
module tb_netlist_bist_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    netlist_bist_ctrl_if bus ();
    netlist_bist_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // stand-in combinational netlist
    function automatic logic [7:0] netlist_f(input logic [13:0] x);
        return ((x[7:0] ^ {x[13:8], x[13:12]}) + {x[3:0], x[11:8]}) ^ (x[13:6] & x[9:2]);
    endfunction

    always_comb begin
        case (mode)
            0:       bus.dut_out = 8'h00;
            1:       bus.dut_out = 8'h01;
            default: bus.dut_out = netlist_f(bus.dut_in);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] lfsr_adv(input logic [13:0] v);
        return {v[12:0], 1'($countones(v & 14'h3802) % 2)};
    endfunction

    function automatic logic [7:0] out_of(input logic [13:0] v);
        case (mode)
            0:       return 8'h00;
            1:       return 8'h01;
            default: return netlist_f(v);
        endcase
    endfunction

    // signature over the first n vectors of the pattern stream
    function automatic logic [7:0] ref_sig(input int n);
        logic [13:0] v = 14'h0001;
        logic [7:0]  m = 8'h00;
        for (int k = 0; k < n; k++) begin
            m = {m[6:0], 1'($countones(m & 8'hB8) % 2)} ^ out_of(v);
            v = lfsr_adv(v);
        end
        return m;
    endfunction

    task automatic run_bist(input string tag, input int n, input logic [7:0] g,
                            input bit poke, output logic [7:0] sig);
        logic [7:0]  exp_sig;
        logic [13:0] v;
        int          cyc, busy_cyc;
        exp_sig  = ref_sig(n);
        v        = 14'h0001;
        cyc      = 1;
        busy_cyc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.num_patterns = 16'(n); bus.golden = g;
        @(negedge clk);
        bus.start = 1'b0; bus.num_patterns = 16'($urandom); bus.golden = 8'($urandom);
        while (bus.done !== 1'b1 && cyc <= n + 4) begin
            chk({tag, ".dut_in"}, 32'(bus.dut_in), 32'((cyc <= n) ? v : 14'h0));
            if (cyc <= n) v = lfsr_adv(v);
            if (bus.busy === 1'b1) busy_cyc++;
            bus.start = poke && (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".done_cyc"}, 32'(cyc), 32'((n == 0) ? 1 : n + 2));
        chk({tag, ".busy_cyc"}, 32'(busy_cyc), 32'((n == 0) ? 0 : n + 1));
        chk({tag, ".sig"}, 32'(bus.signature), 32'(exp_sig));
        chk({tag, ".pass"}, 32'(bus.pass), 32'(exp_sig == g));
        sig = bus.signature;
        bus.start = poke;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'(0));
        chk({tag, ".busy_after"}, 32'(bus.busy), 32'(0));
        chk({tag, ".sig_hold"}, 32'(bus.signature), 32'(exp_sig));
    endtask

    initial begin
        logic [7:0] sig, exp;
        int         n;
        bus.start = 1'b0; bus.num_patterns = '0; bus.golden = '0;
        #1;
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.pass", 32'(bus.pass), 0);
        chk("rst.sig", 32'(bus.signature), 0);
        chk("rst.dut_in", 32'(bus.dut_in), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mode = 0;
        run_bist("t1", 2, 8'h00, 1'b0, sig);
        chk("t1.sig_const", 32'(sig), 32'h00);

        mode = 1;
        run_bist("t2a", 1, 8'h01, 1'b0, sig);
        chk("t2a.sig_const", 32'(sig), 32'h01);
        run_bist("t2b", 2, 8'h02, 1'b0, sig);
        chk("t2b.sig_const", 32'(sig), 32'h03);
        chk("t2b.pass_const", 32'(bus.pass), 32'(0));

        mode = 2;
        run_bist("t3", 0, 8'h00, 1'b0, sig);
        chk("t3.sig_const", 32'(sig), 32'h00);

        for (int i = 0; i < 6; i++) begin
            n   = int'($urandom_range(1, 60));
            exp = ref_sig(n);
            run_bist("rand", n, ($urandom % 2 == 0) ? exp : 8'($urandom), 1'b0, sig);
        end

        run_bist("t4", 1000, ref_sig(1000), 1'b0, sig);
        run_bist("t5", 12, 8'h5A, 1'b1, sig);

        // abort at cnt==5, then confirm a clean rerun
        @(negedge clk);
        bus.start = 1'b1; bus.num_patterns = 16'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6.busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("t6.busy", 32'(bus.busy), 0);
        chk("t6.dut_in", 32'(bus.dut_in), 0);
        chk("t6.done", 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        chk("t6.no_done", 32'(n), 0);
        run_bist("t6.rerun", 20, ref_sig(20), 1'b0, sig);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
